// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver and its matching transmitter.
package serial_word_receiver_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // Bit-order encoding on leftright, identical at both ends of the link.
    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    // One extra bit so the counter can hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Handshake and data bundle between the serial receiver and its environment.
interface serial_word_receiver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             leftright;
    logic             serialin;
    logic             start;
    logic             dready;
    logic             clear_ovr;
    logic [WIDTH-1:0] pdataout;
    logic             dvalid;
    logic             busy;
    logic             overrun;

    modport master (
        output enable, leftright, serialin, start, dready, clear_ovr,
        input  pdataout, dvalid, busy, overrun
    );

    modport slave (
        input  enable, leftright, serialin, start, dready, clear_ovr,
        output pdataout, dvalid, busy, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles WIDTH-bit words from a serial stream (either bit order) and
// presents them through a one-word valid/ready buffer with a sticky overrun flag.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    serial_word_receiver_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    logic             first_bit;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] acc,
                                                  input logic order,
                                                  input logic b);
        if (order == MSB_FIRST) return {acc[WIDTH-2:0], b};
        else                    return {b, acc[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clock) begin : state_reg
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            order_q  <= 1'b0;
            pdata_q  <= '0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            order_q  <= order_d;
            pdata_q  <= pdata_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        pdata_d   = pdata_q;
        dvalid_d  = dvalid_q;
        ovr_d     = ovr_q;
        word_done = 1'b0;
        shifted   = shift_in(acc_q, order_q, bus.serialin);

        // A start strobe restarts the word; with enable it also supplies bit 1.
        first_bit = bus.enable && (bus.start || state_q == IDLE);

        if (bus.start) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end

        if (first_bit) begin
            order_d = bus.leftright;
            acc_d   = shift_in('0, bus.leftright, bus.serialin);
            cnt_d   = CW'(1);
            state_d = RECV;
        end else if (bus.enable && !bus.start) begin
            acc_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
                word_done = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (dvalid_q && bus.dready) dvalid_d = 1'b0;
        if (bus.clear_ovr)          ovr_d    = 1'b0;

        // A completing word reloads the buffer if it is empty or draining now.
        if (word_done) begin
            if (!dvalid_q || bus.dready) begin
                pdata_d  = shifted;
                dvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_comb begin : outputs
        bus.pdataout = pdata_q;
        bus.dvalid   = dvalid_q;
        bus.busy     = busy_q;
        bus.overrun  = ovr_q;
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed self-checking bench for serial_word_receiver with WIDTH=4.
module tb_serial_word_receiver;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_word_receiver_if #(.WIDTH(4)) bus ();

    serial_word_receiver #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic lr);
        bus.enable    = 1'b1;
        bus.serialin  = b;
        bus.leftright = lr;
        tick();
        bus.enable    = 1'b0;
    endtask

    // seq[3] is sent first
    task automatic send_bits(input logic [3:0] seq, input int n, input logic lr);
        logic [3:0] s;
        s = seq;
        for (int i = 0; i < n; i++) bit_in(s[3-i], lr);
    endtask

    task automatic pop();
        bus.dready = 1'b1;
        tick();
        bus.dready = 1'b0;
    endtask

    initial begin
        bus.enable = 0; bus.leftright = 0; bus.serialin = 0;
        bus.start = 0; bus.dready = 0; bus.clear_ovr = 0;
        tick(); tick();
        check("rst_pdata",  8'(bus.pdataout), 8'h0);
        check("rst_dvalid", 8'(bus.dvalid),   8'h0);
        check("rst_busy",   8'(bus.busy),     8'h0);
        check("rst_ovr",    8'(bus.overrun),  8'h0);
        reset = 1'b1;
        tick();

        // MSB-first 1,0,1,1
        send_bits(4'b1011, 3, 1'b1);
        check("msb_busy_mid",   8'(bus.busy),   8'h1);
        check("msb_dvalid_mid", 8'(bus.dvalid), 8'h0);
        bit_in(1'b1, 1'b1);
        check("msb_pdata",  8'(bus.pdataout), 8'hB);
        check("msb_dvalid", 8'(bus.dvalid),   8'h1);
        check("msb_busy",   8'(bus.busy),     8'h0);
        tick();
        check("msb_hold",   8'(bus.pdataout), 8'hB);
        pop();
        check("msb_popped", 8'(bus.dvalid),   8'h0);

        // LSB-first 1,1,0,1 with leftright toggled after the first bit
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        check("lsb_pdata",  8'(bus.pdataout), 8'hB);
        check("lsb_dvalid", 8'(bus.dvalid),   8'h1);
        pop();

        // Abort after two bits, restart with start+enable carrying bit 0
        send_bits(4'b1100, 2, 1'b1);
        bus.start = 1'b1;
        bit_in(1'b0, 1'b1);
        bus.start = 1'b0;
        check("abort_busy",   8'(bus.busy),   8'h1);
        check("abort_dvalid", 8'(bus.dvalid), 8'h0);
        send_bits(4'b1100, 3, 1'b1);
        check("abort_pdata",  8'(bus.pdataout), 8'h6);
        check("abort_dvalid2", 8'(bus.dvalid),  8'h1);
        pop();

        // Overrun: A=0011 buffered, B=1100 dropped
        send_bits(4'b0011, 4, 1'b1);
        send_bits(4'b1100, 4, 1'b1);
        check("ovr_pdata",  8'(bus.pdataout), 8'h3);
        check("ovr_dvalid", 8'(bus.dvalid),   8'h1);
        check("ovr_flag",   8'(bus.overrun),  8'h1);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        check("ovr_cleared", 8'(bus.overrun),  8'h0);
        check("ovr_keep",    8'(bus.pdataout), 8'h3);

        // dready on the same edge as B's last bit, A still buffered
        send_bits(4'b1100, 3, 1'b1);
        bus.dready = 1'b1;
        bit_in(1'b0, 1'b1);
        bus.dready = 1'b0;
        check("simul_dvalid", 8'(bus.dvalid),   8'h1);
        check("simul_pdata",  8'(bus.pdataout), 8'hC);
        check("simul_ovr",    8'(bus.overrun),  8'h0);

        // Overrun set, then clear_ovr coinciding with another overrun
        send_bits(4'b1111, 4, 1'b1);
        check("ovr2_flag", 8'(bus.overrun), 8'h1);
        send_bits(4'b0101, 3, 1'b1);
        bus.clear_ovr = 1'b1;
        bit_in(1'b1, 1'b1);
        bus.clear_ovr = 1'b0;
        check("setwins_ovr",   8'(bus.overrun),  8'h1);
        check("setwins_pdata", 8'(bus.pdataout), 8'hC);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        check("setwins_clr", 8'(bus.overrun), 8'h0);

        // Reset with 3 bits in flight and a word buffered
        send_bits(4'b1110, 3, 1'b1);
        check("pre_rst_busy", 8'(bus.busy), 8'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mrst_pdata",  8'(bus.pdataout), 8'h0);
        check("mrst_dvalid", 8'(bus.dvalid),   8'h0);
        check("mrst_busy",   8'(bus.busy),     8'h0);
        check("mrst_ovr",    8'(bus.overrun),  8'h0);
        send_bits(4'b1001, 4, 1'b1);
        check("post_pdata",  8'(bus.pdataout), 8'h9);
        check("post_dvalid", 8'(bus.dvalid),   8'h1);
        check("post_busy",   8'(bus.busy),     8'h0);

        // dready with an empty buffer is ignored; enable=0 holds everything
        pop();
        pop();
        check("idle_dvalid", 8'(bus.dvalid), 8'h0);
        send_bits(4'b0110, 2, 1'b0);
        tick(); tick();
        check("hold_busy", 8'(bus.busy), 8'h1);
        send_bits(4'b1000, 2, 1'b0);
        // LSB-first 0,1,1,0 -> bit0=0 bit1=1 bit2=1 bit3=0
        check("hold_pdata", 8'(bus.pdataout), 8'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
